cntr_sched_nb: RTL and testbench

- Scheduler that shares one external n-bit up-counter (clr/up/ld/D/count/rco interface) between NREQ requesters.
- Each requester asks for a delay. The block arbitrates round-robin, loads the counter so its RCO fires after the requested interval, and pulses a per-requester done.
- Sits between MCU-side timer clients (e.g. periodic sampling, debounce, interrupt timers) and the shared counter instance.

---
 rtl/cntr_sched_nb_pkg.sv | 21 ++
 rtl/cntr_sched_nb_rr_arb.sv | 43 ++++
 rtl/cntr_sched_nb.sv | 129 ++++++++++++
 tb/tb_cntr_sched_nb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_sched_nb_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding,
// default sizing and a helper for requester-index widths.
package cntr_sched_nb_pkg;

  localparam int DEFAULT_N    = 8;
  localparam int DEFAULT_NREQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Bits needed to hold a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/cntr_sched_nb_rr_arb.sv
// Combinational round-robin arbiter: rotate requests so the pointer sits at
// bit 0, take the lowest set bit, then rotate the winner index back.
module rr_arb_nb
  import cntr_sched_nb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int                pos;
  int                sum;

  // Rotate, priority-pick the lowest rotated bit, and map back to a real index.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr);
    pos     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pos = i;
      end
    end
    any = |req_rot;
    sum = pos + int'(ptr);
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    idx = IDX_W'(sum);
    gnt = '0;
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cntr_sched_nb.sv
// Shares one external up-counter among NREQ timer clients. A winner is chosen
// round-robin, the counter is preloaded with ~delay so its RCO fires after
// delay+1 counting cycles, and the owner receives a one-cycle done pulse.
module cntr_sched_nb
  import cntr_sched_nb_pkg::*;
#(
  parameter int n    = DEFAULT_N,
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] delay,
  input  logic              pause,
  input  logic              abort,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic              cntr_clr,
  output logic              cntr_ld,
  output logic              cntr_up,
  output logic [n-1:0]      cntr_D,
  input  logic              cntr_rco
);

  localparam int IDX_W = idx_width(NREQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [n-1:0]     load_val_q, load_val_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;
  logic [n-1:0]     delay_sel;
  logic [IDX_W-1:0] ptr_after_owner;

  rr_arb_nb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Select the delay slice of the current arbitration winner.
  always_comb begin
    delay_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        delay_sel = delay[i*n +: n];
      end
    end
  end

  // Next state, pointer advance and the registers captured at grant time.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    load_val_d = load_val_q;
    if (idx_q == IDX_W'(NREQ - 1)) begin
      ptr_after_owner = '0;
    end else begin
      ptr_after_owner = idx_q + IDX_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          idx_d      = arb_idx;
          grant_d    = arb_gnt;
          load_val_d = ~delay_sel;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = abort ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_FLUSH;
        end else if (cntr_up && cntr_rco) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_FLUSH: begin
        grant_d = '0;
        ptr_d   = ptr_after_owner;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by clr_n.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      load_val_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      load_val_q <= load_val_d;
    end
  end

  // The counter is held cleared while the scheduler is in reset as well as during FLUSH.
  assign cntr_clr = ~clr_n | (state_q == ST_FLUSH);
  assign cntr_ld  = (state_q == ST_LOAD);
  assign cntr_up  = (state_q == ST_RUN) & ~pause;
  assign cntr_D   = load_val_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;
  assign done     = (state_q == ST_DONE) ? grant_q : '0;

endmodule

// File: tb/tb_cntr_sched_nb.sv
// Scoreboard bench for cntr_sched_nb with a behavioural up-counter attached.
// Stimulus episodes are planned at transaction level (round-robin order and
// interval arithmetic), and expectations are queued for an independent monitor.
module tb_cntr_sched_nb;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int MAXL = 4096;

  logic              clk = 1'b0;
  logic              clr_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] delay;
  logic              pause;
  logic              abort;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [NREQ-1:0]   done;
  logic              cntr_clr;
  logic              cntr_ld;
  logic              cntr_up;
  logic [N-1:0]      cntr_D;
  logic              cntr_rco;
  logic [N-1:0]      count;

  typedef struct {
    int           idx;
    int           cyc;
    logic [N-1:0] dval;
  } gexp_t;

  typedef struct {
    int idx;
    int cyc;
    int ups;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int    fq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_ptr = 0;
  int up_cnt   = 0;
  bit prev_end = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External n-bit counter: clear beats load beats count; holds when up is low.
  always @(posedge clk) begin
    if (cntr_clr) count <= '0;
    else if (cntr_ld) count <= cntr_D;
    else if (cntr_up) count <= count + 1'b1;
  end

  assign cntr_rco = cntr_up ? (&count) : (count == '0);

  cntr_sched_nb #(.n(N), .NREQ(NREQ)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .req      (req),
    .delay    (delay),
    .pause    (pause),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .cntr_clr (cntr_clr),
    .cntr_ld  (cntr_ld),
    .cntr_up  (cntr_up),
    .cntr_D   (cntr_D),
    .cntr_rco (cntr_rco)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int firstPending(input logic [NREQ-1:0] p, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT loads, completes or flushes.
  always @(negedge clk) begin
    if (!clr_n) begin
      prev_end = 1'b0;
    end else begin
      if (prev_end) begin
        checkOutput("grant_cleared", 64'(grant), 64'd0);
        checkOutput("busy_after_end", 64'(busy), 64'd0);
      end
      if (cntr_ld) begin
        up_cnt = 0;
        if (gq.size() == 0) begin
          checkOutput("unexpected_load", 64'd1, 64'd0);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          checkOutput("grant_onehot", 64'(grant), 64'(NREQ'(1) << g.idx));
          checkOutput("load_value", 64'(cntr_D), 64'(g.dval));
          checkOutput("load_cycle", 64'(cyc), 64'(g.cyc));
        end
      end
      if (cntr_up) up_cnt++;
      if (pause) checkOutput("up_while_paused", 64'(cntr_up), 64'd0);
      if (done != '0) begin
        if (dq.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          checkOutput("done_vector", 64'(done), 64'(NREQ'(1) << e.idx));
          checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("run_up_cycles", 64'(up_cnt), 64'(e.ups));
        end
      end
      if (cntr_clr) begin
        checkOutput("flush_no_done", 64'(done), 64'd0);
        if (fq.size() == 0) begin
          checkOutput("unexpected_flush", 64'd1, 64'd0);
        end else begin
          int f;
          f = fq.pop_front();
          checkOutput("flush_cycle", 64'(cyc), 64'(f));
        end
      end
      prev_end = (done != '0) || cntr_clr;
    end
  end

  // Plans one episode (all requesters in pattern served once) and drives it.
  // mode: 0 random, 1 plain, 2 pause at RUN offset p1 for p2 cycles,
  //       3 abort at RUN offset p1 (-1 = during LOAD), 4 abort during DONE.
  task automatic applyStimulus(input logic [NREQ-1:0] pattern, input logic [NREQ*N-1:0] dly,
                               input int mode, input int p1, input int p2);
    logic            pause_s [0:MAXL-1];
    logic            abort_s [0:MAXL-1];
    logic [NREQ-1:0] drop_s  [0:MAXL-1];
    int              own_from [NREQ];
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] live;
    logic [NREQ*N-1:0] dbus;
    logic [N-1:0]    dv;
    int t, t0, w, d, ao, po, pl, fin, sel, r;
    t0 = cyc;
    for (int k = 0; k < MAXL; k++) begin
      pause_s[k] = 1'b0;
      abort_s[k] = 1'b0;
      drop_s[k]  = '0;
    end
    for (int i = 0; i < NREQ; i++) own_from[i] = MAXL;
    pending = pattern;
    t = 0;
    while (pending != '0) begin
      w  = firstPending(pending, model_ptr);
      dv = dly[w*N +: N];
      d  = int'(dv);
      own_from[w] = t;
      sel = mode;
      if (mode == 0) begin
        r = int'($urandom_range(0, 9));
        sel = (r < 2) ? 3 : ((r < 5) ? 2 : 1);
      end
      ao = 0; po = 0; pl = 0;
      if (sel == 3) ao = (mode == 0) ? int'($urandom_range(0, d + 1)) - 1 : ((p1 > d) ? d : p1);
      if (sel == 2) begin
        po = (mode == 0) ? int'($urandom_range(0, d)) : ((p1 > d) ? d : p1);
        pl = (mode == 0) ? int'($urandom_range(1, 4)) : p2;
      end
      gq.push_back('{w, t0 + t + 1, ~dv});
      if (mode == 0 && $urandom_range(0, 3) == 0) abort_s[t] = 1'b1;
      if (sel == 3) begin
        fin = t + 3 + ao;
        abort_s[fin-1] = 1'b1;
        fq.push_back(t0 + fin);
      end else begin
        fin = t + 3 + d + pl;
        for (int k = 0; k < pl; k++) pause_s[t+2+po+k] = 1'b1;
        dq.push_back('{w, t0 + fin, d + 1});
        if (sel == 4 || (mode == 0 && $urandom_range(0, 3) == 0)) abort_s[fin] = 1'b1;
      end
      drop_s[fin][w] = 1'b1;
      pending[w] = 1'b0;
      model_ptr = (w + 1) % NREQ;
      t = fin + 1;
    end
    live = pattern;
    for (int k = 0; k <= t; k++) begin
      live = live & ~drop_s[k];
      dbus = dly;
      for (int i = 0; i < NREQ; i++) begin
        if (k > own_from[i]) dbus[i*N +: N] = N'($urandom);
      end
      req   = live;
      delay = dbus;
      pause = pause_s[k];
      abort = abort_s[k];
      @(posedge clk); #1;
    end
    pause = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_ld"}, 64'(cntr_ld), 64'd0);
    checkOutput({tag, "_up"}, 64'(cntr_up), 64'd0);
    checkOutput({tag, "_clr"}, 64'(cntr_clr), 64'd1);
    checkOutput({tag, "_D"}, 64'(cntr_D), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0]   pat;
    logic [NREQ*N-1:0] dl;
    clr_n = 1'b0;
    req   = '0;
    delay = '0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    clr_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_clr", 64'(cntr_clr), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    model_ptr = 0;

    $display("[TB] directed episodes");
    applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 1, 0, 0);
    applyStimulus(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1}, 1, 0, 0);
    applyStimulus(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 2, 2, 3);
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, 3, 1, 0);
    applyStimulus(4'b1000, {8'd2, 8'd0, 8'd0, 8'd0}, 4, 0, 0);
    applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 3, -1, 0);
    applyStimulus(4'b0010, {8'd0, 8'd0, 8'd0, 8'd0}, 1, 0, 0);
    applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'hFF}, 1, 0, 0);
    applyStimulus(4'b0100, {8'd0, 8'hFF, 8'd0, 8'd0}, 2, 0, 3);

    $display("[TB] random episodes");
    for (int ep = 0; ep < 40; ep++) begin
      pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        dl[i*N +: N] = ($urandom_range(0, 19) == 0) ? 8'hFF : N'($urandom_range(0, 15));
      end
      applyStimulus(pat, dl, 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] reset during RUN");
    applyStimulus(4'b0100, {8'd0, 8'd1, 8'd0, 8'd0}, 1, 0, 0);
    gq.push_back('{0, cyc + 1, 8'hCD});
    req   = 4'b0001;
    delay = {8'd0, 8'd0, 8'd0, 8'd50};
    repeat (10) begin
      @(posedge clk); #1;
    end
    clr_n = 1'b0;
    #1;
    checkResetValues("midrun_reset");
    req = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    clr_n = 1'b1;
    model_ptr = 0;
    @(posedge clk); #1;
    applyStimulus(4'b1111, {8'd2, 8'd2, 8'd2, 8'd2}, 1, 0, 0);

    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("leftover_grants", 64'(gq.size()), 64'd0);
    checkOutput("leftover_dones", 64'(dq.size()), 64'd0);
    checkOutput("leftover_flushes", 64'(fq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
